// File: rtl/mole_grid_display.sv
// Whack-a-mole VGA renderer: sync timing, slot grid, active mole, score bar and
// frame-synchronous green/red flash feedback. All outputs are registered with a
// single clock of latency, so colour and syncs stay mutually aligned.
module mole_grid_display #(
   parameter int unsigned H_ACTIVE     = 640,
   parameter int unsigned H_FP         = 16,
   parameter int unsigned H_SYNC       = 96,
   parameter int unsigned H_BP         = 48,
   parameter int unsigned V_ACTIVE     = 480,
   parameter int unsigned V_FP         = 10,
   parameter int unsigned V_SYNC       = 2,
   parameter int unsigned V_BP         = 29,
   parameter int unsigned GRID_ROWS    = 3,
   parameter int unsigned GRID_COLS    = 3,
   parameter int unsigned SLOT_SIZE    = 100,
   parameter int unsigned SLOT_GAP     = 50,
   parameter int unsigned GRID_X0      = 95,
   parameter int unsigned GRID_Y0      = 20,
   parameter int unsigned MOLE_INSET   = 20,
   parameter int unsigned FLASH_FRAMES = 15,
   parameter int unsigned SCORE_W      = 8,
   localparam int unsigned IDX_W       = ($clog2(GRID_ROWS * GRID_COLS) > 0) ?
                                         $clog2(GRID_ROWS * GRID_COLS) : 1
) (
   input  logic               clk_pixel,
   input  logic               rst_n,
   input  logic [IDX_W-1:0]   mole_idx,
   input  logic               mole_valid,
   input  logic [SCORE_W-1:0] score,
   input  logic               guess_correct,
   input  logic               guess_wrong,
   output logic               hsync,
   output logic               vsync,
   output logic [2:0]         red,
   output logic [2:0]         green,
   output logic [1:0]         blue,
   output logic               frame_start
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HC_W    = $clog2(H_TOTAL);
   localparam int unsigned VC_W    = $clog2(V_TOTAL);
   localparam int unsigned PITCH   = SLOT_SIZE + SLOT_GAP;
   localparam int unsigned OFF_W   = $clog2(PITCH + 1);
   localparam int unsigned AX_W    = 4;

   localparam logic [HC_W-1:0] HC_LAST = HC_W'(H_TOTAL - 1);
   localparam logic [HC_W-1:0] H_ACT   = HC_W'(H_ACTIVE);
   localparam logic [HC_W-1:0] HS_BEG  = HC_W'(H_ACTIVE + H_FP);
   localparam logic [HC_W-1:0] HS_END  = HC_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HC_W-1:0] H_X0    = HC_W'(GRID_X0);
   localparam logic [VC_W-1:0] VC_LAST = VC_W'(V_TOTAL - 1);
   localparam logic [VC_W-1:0] V_ACT   = VC_W'(V_ACTIVE);
   localparam logic [VC_W-1:0] VS_BEG  = VC_W'(V_ACTIVE + V_FP);
   localparam logic [VC_W-1:0] VS_END  = VC_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VC_W-1:0] V_Y0    = VC_W'(GRID_Y0);
   localparam logic [VC_W-1:0] BAR_TOP = VC_W'(V_ACTIVE - 12);
   localparam logic [VC_W-1:0] BAR_BOT = VC_W'(V_ACTIVE - 5);

   localparam logic [OFF_W-1:0] OFF_LAST  = OFF_W'(PITCH - 1);
   localparam logic [OFF_W-1:0] SLOT_C    = OFF_W'(SLOT_SIZE);
   localparam logic [OFF_W-1:0] INSET_C   = OFF_W'(MOLE_INSET);
   localparam logic [OFF_W-1:0] INSET_END = OFF_W'(SLOT_SIZE - MOLE_INSET);
   localparam logic [AX_W-1:0]  AX_SAT    = '1;
   localparam logic [AX_W-1:0]  COLS_C    = AX_W'(GRID_COLS);
   localparam logic [AX_W-1:0]  ROWS_C    = AX_W'(GRID_ROWS);
   localparam logic [7:0]       NSLOT_C   = 8'(GRID_ROWS * GRID_COLS);
   localparam logic [7:0]       FLASH_C   = 8'(FLASH_FRAMES);

   localparam logic [7:0] COL_BLACK  = 8'b000_000_00;
   localparam logic [7:0] COL_YELLOW = 8'b111_111_00;
   localparam logic [7:0] COL_WHITE  = 8'b111_111_11;
   localparam logic [7:0] COL_BLUE   = 8'b000_000_11;
   localparam logic [7:0] COL_GREEN  = 8'b000_111_00;
   localparam logic [7:0] COL_RED    = 8'b111_000_00;

   typedef enum logic [1:0] {StIdle, StFlashOk, StFlashBad} flash_e;

   logic [HC_W-1:0] hc_q, hc_d;
   logic [VC_W-1:0] vc_q, vc_d;
   logic            line_end;
   logic            fs_w;

   logic             x_in_q, x_in_d;
   logic [OFF_W-1:0] x_off_q, x_off_d;
   logic [AX_W-1:0]  x_idx_q, x_idx_d;
   logic             y_in_q, y_in_d;
   logic [OFF_W-1:0] y_off_q, y_off_d;
   logic [AX_W-1:0]  y_idx_q, y_idx_d;
   logic [7:0]       y_base_q, y_base_d;

   logic [IDX_W-1:0]   mole_idx_q, mole_idx_d;
   logic               mole_valid_q, mole_valid_d;
   logic [SCORE_W-1:0] score_q, score_d;

   flash_e     st_q, st_d;
   logic [7:0] cnt_q, cnt_d;
   logic       pend_ok_q, pend_ok_d;
   logic       pend_bad_q, pend_bad_d;
   logic       ok_ev, bad_ev;
   logic       flash_ok, flash_bad;

   logic       active, slot_hit, mole_hit, bar_hit, mole_ok;
   logic [7:0] slot_num;
   logic [7:0] pix;
   logic [7:0] rgb_q;
   logic       hs_q, vs_q, fs_q;

   // Raster counters: hc wraps each line, vc advances on the line wrap.
   always_comb begin
      line_end = (hc_q == HC_LAST);
      hc_d     = line_end ? '0 : hc_q + HC_W'(1);
      vc_d     = vc_q;
      if (line_end) begin
         vc_d = (vc_q == VC_LAST) ? '0 : vc_q + VC_W'(1);
      end
      fs_w = (hc_q == '0) && (vc_q == '0);
   end

   // Column tracker: restarts at GRID_X0 and steps with hc, avoiding any divide on hc.
   always_comb begin
      x_in_d  = x_in_q;
      x_off_d = x_off_q;
      x_idx_d = x_idx_q;
      if (hc_d == H_X0) begin
         x_in_d  = 1'b1;
         x_off_d = '0;
         x_idx_d = '0;
      end else if (hc_d == '0) begin
         x_in_d = 1'b0;
      end else if (x_in_q) begin
         if (x_off_q == OFF_LAST) begin
            x_off_d = '0;
            if (x_idx_q != AX_SAT) x_idx_d = x_idx_q + AX_W'(1);
         end else begin
            x_off_d = x_off_q + OFF_W'(1);
         end
      end
   end

   // Row tracker: same scheme per line; y_base holds row*GRID_COLS built by addition.
   always_comb begin
      y_in_d   = y_in_q;
      y_off_d  = y_off_q;
      y_idx_d  = y_idx_q;
      y_base_d = y_base_q;
      if (line_end) begin
         if (vc_d == V_Y0) begin
            y_in_d   = 1'b1;
            y_off_d  = '0;
            y_idx_d  = '0;
            y_base_d = '0;
         end else if (vc_d == '0) begin
            y_in_d = 1'b0;
         end else if (y_in_q) begin
            if (y_off_q == OFF_LAST) begin
               y_off_d = '0;
               if (y_idx_q != AX_SAT) begin
                  y_idx_d  = y_idx_q + AX_W'(1);
                  y_base_d = y_base_q + 8'(GRID_COLS);
               end
            end else begin
               y_off_d = y_off_q + OFF_W'(1);
            end
         end
      end
   end

   // Counter and tracker state.
   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         hc_q     <= '0;
         vc_q     <= '0;
         x_in_q   <= (GRID_X0 == 0);
         x_off_q  <= '0;
         x_idx_q  <= '0;
         y_in_q   <= (GRID_Y0 == 0);
         y_off_q  <= '0;
         y_idx_q  <= '0;
         y_base_q <= '0;
      end else begin
         hc_q     <= hc_d;
         vc_q     <= vc_d;
         x_in_q   <= x_in_d;
         x_off_q  <= x_off_d;
         x_idx_q  <= x_idx_d;
         y_in_q   <= y_in_d;
         y_off_q  <= y_off_d;
         y_idx_q  <= y_idx_d;
         y_base_q <= y_base_d;
      end
   end

   // Frame-latched inputs; the _d values feed the renderer so pixel (0,0) already sees them.
   always_comb begin
      mole_idx_d   = fs_w ? mole_idx   : mole_idx_q;
      mole_valid_d = fs_w ? mole_valid : mole_valid_q;
      score_d      = fs_w ? score      : score_q;
   end

   // Latched game inputs.
   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         mole_idx_q   <= '0;
         mole_valid_q <= 1'b0;
         score_q      <= '0;
      end else begin
         mole_idx_q   <= mole_idx_d;
         mole_valid_q <= mole_valid_d;
         score_q      <= score_d;
      end
   end

   // Flash FSM state register, including pending guess flags and frame counter.
   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         st_q       <= StIdle;
         cnt_q      <= '0;
         pend_ok_q  <= 1'b0;
         pend_bad_q <= 1'b0;
      end else begin
         st_q       <= st_d;
         cnt_q      <= cnt_d;
         pend_ok_q  <= pend_ok_d;
         pend_bad_q <= pend_bad_d;
      end
   end

   // Flash FSM next state: only frame_start moves it; a pulse on that same cycle is consumed too.
   always_comb begin
      ok_ev      = pend_ok_q | guess_correct;
      bad_ev     = pend_bad_q | guess_wrong;
      st_d       = st_q;
      cnt_d      = cnt_q;
      pend_ok_d  = ok_ev;
      pend_bad_d = bad_ev;
      if (fs_w) begin
         pend_ok_d  = 1'b0;
         pend_bad_d = 1'b0;
         if (bad_ev) begin
            st_d  = StFlashBad;
            cnt_d = FLASH_C;
         end else if (ok_ev) begin
            st_d  = StFlashOk;
            cnt_d = FLASH_C;
         end else if (st_q != StIdle) begin
            if (cnt_q <= 8'd1) begin
               st_d  = StIdle;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
      end
   end

   // Flash FSM outputs, decoded from the next state so a new flash covers the whole frame.
   always_comb begin
      flash_ok  = 1'b0;
      flash_bad = 1'b0;
      unique case (st_d)
         StFlashOk:  flash_ok  = 1'b1;
         StFlashBad: flash_bad = 1'b1;
         default:    ;
      endcase
   end

   // Pixel classification and colour priority with flash override.
   always_comb begin
      active   = (hc_q < H_ACT) && (vc_q < V_ACT);
      slot_hit = x_in_q && (x_off_q < SLOT_C) && (x_idx_q < COLS_C) &&
                 y_in_q && (y_off_q < SLOT_C) && (y_idx_q < ROWS_C);
      slot_num = y_base_q + 8'(x_idx_q);
      mole_ok  = mole_valid_d && (8'(mole_idx_d) < NSLOT_C);
      mole_hit = slot_hit && mole_ok && (slot_num == 8'(mole_idx_d)) &&
                 (x_off_q >= INSET_C) && (x_off_q < INSET_END) &&
                 (y_off_q >= INSET_C) && (y_off_q < INSET_END);
      // Widened so 2*score never wraps; the bar then clips naturally at the active edge.
      bar_hit  = (vc_q >= BAR_TOP) && (vc_q <= BAR_BOT) &&
                 (32'(hc_q) < (32'(score_d) << 1));
      pix = COL_BLACK;
      if (active) begin
         if (mole_hit) begin
            pix = COL_YELLOW;
         end else if (slot_hit) begin
            pix = COL_WHITE;
         end else if (bar_hit) begin
            pix = COL_BLUE;
         end
      end
      if (pix != COL_BLACK) begin
         if (flash_bad) begin
            pix = COL_RED;
         end else if (flash_ok) begin
            pix = COL_GREEN;
         end
      end
   end

   // Output register: colour, syncs and frame_start share one stage of latency.
   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         rgb_q <= '0;
         hs_q  <= 1'b1;
         vs_q  <= 1'b1;
         fs_q  <= 1'b0;
      end else begin
         rgb_q <= pix;
         hs_q  <= !((hc_q >= HS_BEG) && (hc_q < HS_END));
         vs_q  <= !((vc_q >= VS_BEG) && (vc_q < VS_END));
         fs_q  <= fs_w;
      end
   end

   assign red         = rgb_q[7:5];
   assign green       = rgb_q[4:2];
   assign blue        = rgb_q[1:0];
   assign hsync       = hs_q;
   assign vsync       = vs_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_mole_grid_display.sv
// Directed bench for mole_grid_display on a shrunken raster (48x44 clocks per frame)
// so multi-frame flash behaviour fits in a short run.
module tb_mole_grid_display;

   localparam int HT    = 48;
   localparam int VT    = 44;
   localparam int FRAME = HT * VT;

   localparam logic [7:0] BLACK  = 8'h00;
   localparam logic [7:0] YELLOW = 8'hFC;
   localparam logic [7:0] WHITE  = 8'hFF;
   localparam logic [7:0] BLUE   = 8'h03;
   localparam logic [7:0] GREEN  = 8'h1C;
   localparam logic [7:0] RED    = 8'hE0;

   logic       clk_pixel = 1'b0;
   logic       rst_n;
   logic [3:0] mole_idx;
   logic       mole_valid;
   logic [7:0] score;
   logic       guess_correct;
   logic       guess_wrong;
   logic       hsync, vsync, frame_start;
   logic [2:0] red, green;
   logic [1:0] blue;
   logic [7:0] rgb;

   int n_checks = 0;
   int n_errors = 0;
   int pos      = -1000000;

   assign rgb = {red, green, blue};

   always #5 clk_pixel = ~clk_pixel;

   mole_grid_display #(
      .H_ACTIVE(40), .H_FP(2), .H_SYNC(4), .H_BP(2),
      .V_ACTIVE(40), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .GRID_ROWS(3), .GRID_COLS(3), .SLOT_SIZE(8), .SLOT_GAP(3),
      .GRID_X0(2), .GRID_Y0(1), .MOLE_INSET(2), .FLASH_FRAMES(3), .SCORE_W(8)
   ) dut (
      .clk_pixel     (clk_pixel),
      .rst_n         (rst_n),
      .mole_idx      (mole_idx),
      .mole_valid    (mole_valid),
      .score         (score),
      .guess_correct (guess_correct),
      .guess_wrong   (guess_wrong),
      .hsync         (hsync),
      .vsync         (vsync),
      .red           (red),
      .green         (green),
      .blue          (blue),
      .frame_start   (frame_start)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // pos = raster index of the pixel currently shown on the outputs
   task automatic tick();
      @(negedge clk_pixel);
      if (frame_start) pos = 0;
      else pos++;
   endtask

   task automatic goto_px(input int x, input int y);
      int target;
      int n;
      target = y * HT + x;
      n = 0;
      while (pos != target && n < 2 * FRAME) begin
         tick();
         n++;
      end
      if (pos != target) chk("goto_timeout", 32'(pos), 32'(target));
   endtask

   task automatic new_frame();
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (pos != 0 && n < 2 * FRAME);
      if (pos != 0) chk("frame_timeout", 32'(pos), 32'(0));
   endtask

   task automatic px(input string tag, input int x, input int y, input logic [7:0] exp);
      goto_px(x, y);
      chk(tag, 32'(rgb), 32'(exp));
   endtask

   task automatic pulse(input logic ok, input logic bad);
      guess_correct = ok;
      guess_wrong   = bad;
      tick();
      guess_correct = 1'b0;
      guess_wrong   = 1'b0;
   endtask

   initial begin
      int n;
      int yellow_cnt;
      rst_n         = 1'b0;
      mole_idx      = 4'd4;
      mole_valid    = 1'b1;
      score         = 8'd0;
      guess_correct = 1'b0;
      guess_wrong   = 1'b0;
      repeat (3) @(negedge clk_pixel);
      chk("rst_rgb", 32'(rgb), 32'(0));
      chk("rst_hsync", 32'(hsync), 32'(1));
      chk("rst_vsync", 32'(vsync), 32'(1));
      chk("rst_fs", 32'(frame_start), 32'(0));

      rst_n = 1'b1;
      tick();
      chk("fs_first", 32'(frame_start), 32'(1));
      n = 0;
      do begin
         tick();
         n++;
      end while (!frame_start && n < 3 * FRAME);
      chk("frame_period", 32'(n), 32'(FRAME));

      goto_px(41, 1);  chk("hs_before", 32'(hsync), 32'(1));
      goto_px(42, 1);  chk("hs_fall", 32'(hsync), 32'(0));
      goto_px(45, 1);  chk("hs_last", 32'(hsync), 32'(0));
      goto_px(46, 1);  chk("hs_rise", 32'(hsync), 32'(1));
      goto_px(0, 40);  chk("vs_before", 32'(vsync), 32'(1));
      goto_px(0, 41);  chk("vs_fall", 32'(vsync), 32'(0));
      goto_px(47, 42); chk("vs_last", 32'(vsync), 32'(0));
      goto_px(0, 43);  chk("vs_rise", 32'(vsync), 32'(1));

      // mole 4 = row 1, col 1: slot x 13..20 y 12..19, mole x 15..18 y 14..17
      new_frame();
      px("slot0_corner", 2, 1, WHITE);
      px("slot4_edge", 13, 15, WHITE);
      px("mole_center", 16, 15, YELLOW);
      px("mole_right", 18, 15, YELLOW);
      px("mole_after", 19, 15, WHITE);
      px("gap_after", 21, 15, BLACK);
      px("slot8_corner", 31, 30, WHITE);
      px("past_grid", 32, 30, BLACK);

      mole_idx = 4'd9;
      new_frame();
      yellow_cnt = 0;
      for (int i = 0; i < FRAME; i++) begin
         if (rgb == YELLOW) yellow_cnt++;
         if (i != FRAME - 1) tick();
      end
      chk("idx9_no_yellow", 32'(yellow_cnt), 32'(0));

      mole_idx   = 4'd4;
      mole_valid = 1'b0;
      new_frame();
      px("mole_invalid", 16, 15, WHITE);
      mole_valid = 1'b1;

      // score bar on lines 28..35
      score = 8'd5;
      new_frame();
      px("bar_above", 0, 27, BLACK);
      px("bar_top", 0, 28, BLUE);
      px("bar_end", 9, 32, BLUE);
      px("bar_past", 10, 32, BLACK);
      px("bar_bottom", 0, 35, BLUE);
      px("bar_below", 0, 36, BLACK);
      score = 8'd140;
      new_frame();
      px("bar140_x30", 30, 32, BLUE);
      px("bar140_x39", 39, 32, BLUE);
      score = 8'd255;
      new_frame();
      px("bar255_x39", 39, 32, BLUE);
      score = 8'd0;
      new_frame();
      px("bar0", 0, 32, BLACK);
      score = 8'd5;

      // mole changes mid-frame: takes effect only at the next frame
      mole_idx = 4'd3;
      new_frame();
      goto_px(0, 5);
      mole_idx = 4'd5;
      px("mid_old_mole", 5, 15, YELLOW);
      px("mid_new_slot", 27, 15, WHITE);
      new_frame();
      px("next_old_slot", 5, 15, WHITE);
      px("next_new_mole", 27, 15, YELLOW);

      // single correct guess: green for exactly 3 frames
      mole_idx = 4'd4;
      new_frame();
      goto_px(0, 20);
      pulse(1'b1, 1'b0);
      px("ok_same_frame", 2, 23, WHITE);
      for (int f = 1; f <= 3; f++) begin
         new_frame();
         px($sformatf("ok_flash_f%0d", f), 2, 1, GREEN);
         if (f == 1) begin
            px("ok_flash_mole", 16, 15, GREEN);
            px("ok_flash_black", 21, 15, BLACK);
            px("ok_flash_bar", 0, 32, GREEN);
         end
      end
      new_frame();
      px("ok_flash_done", 2, 1, WHITE);

      // both pulses together: red wins; correct during red restarts as green
      goto_px(0, 20);
      pulse(1'b1, 1'b1);
      new_frame();
      px("bad_flash_f1", 2, 1, RED);
      new_frame();
      px("bad_flash_f2", 2, 1, RED);
      goto_px(0, 20);
      pulse(1'b1, 1'b0);
      for (int f = 1; f <= 3; f++) begin
         new_frame();
         px($sformatf("restart_ok_f%0d", f), 2, 1, GREEN);
      end
      new_frame();
      px("restart_done", 2, 1, WHITE);

      // asynchronous reset mid-frame on a lit pixel
      goto_px(2, 30);
      rst_n = 1'b0;
      #1;
      chk("midrst_rgb", 32'(rgb), 32'(0));
      chk("midrst_hsync", 32'(hsync), 32'(1));
      chk("midrst_vsync", 32'(vsync), 32'(1));
      chk("midrst_fs", 32'(frame_start), 32'(0));
      repeat (3) @(negedge clk_pixel);
      rst_n = 1'b1;
      tick();
      chk("postrst_fs", 32'(frame_start), 32'(1));
      px("postrst_mole", 16, 15, YELLOW);
      goto_px(42, 16);
      chk("postrst_hs", 32'(hsync), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
